unsigned_seq_divider: RTL and testbench
=======================================

# unsigned_seq_divider

Sequential restoring unsigned divider: a 2·W-bit dividend by a W-bit divisor gives a W-bit quotient and a W-bit remainder, one quotient bit per clock. It is the inverse-direction companion to the team's unsigned W×W multipliers. It recovers operands from products in the error-evaluation datapath, and it checks approximate-multiplier outputs (z / y against x) in the characterisation harness. Valid/ready handshakes on both sides let it sit between the product stream and the scoreboard logic.

## Interface
- W, default 8: operand width; dividend is 2·W bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept an operation.
- dividend  input  2·W  unsigned dividend (a multiplier product z).
- divisor  input  W  unsigned divisor (a multiplier operand y).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- quotient  output  W  unsigned quotient.
- remainder  output  W  unsigned remainder.
- err  output  1  divide-by-zero or quotient overflow (only with DIV_OVF_CHECK_EN).

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating, W cycles.
  - DONE: out_valid=1.
- IDLE, in_valid=1: latch divisor. Load partial remainder R (W+1 bits) with dividend[2W-1:W], and shift register Q with dividend[W-1:0]. Clear step counter and go to BUSY.
- BUSY, each cycle:
  - T = {R[W-1:0], Q[W-1]}.
  - If T ≥ {1'b0, divisor}: R = T − divisor and Q = {Q[W-2:0], 1}.
  - Otherwise: R = T and Q = {Q[W-2:0], 0}.
  - Increment the counter. After the W-th step go to DONE.
- DONE: quotient=Q and remainder=R[W-1:0], held stable while out_valid=1 and out_ready=0. When out_ready=1, go to IDLE.
- Results are exact whenever dividend[2W-1:W] < divisor, which holds for every product z = x·y with y≠0.
- in_ready is low in BUSY and DONE, so no accept happens in the cycle a result drains. in_valid while busy is ignored; the operand source must hold it.
- Operands are captured only at acceptance. Input changes afterwards do not affect the result.

## Timing
- Reset (asynchronous, any state, including mid-BUSY): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, err=0, counter=0. The operation in flight is discarded.
- Let edge A be the accept edge (in_valid & in_ready). Iterations happen at edges A+1 … A+W. out_valid is high after edge A+W (latency W clocks; 8 for W=8).
- Let edge D be the first edge with out_valid & out_ready. in_ready is high after edge D. The next accept is at D+1 at the earliest, so throughput is one operation per W+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DIV_OVF_CHECK_EN defined:
  - At acceptance, test divisor==0 or dividend[2W-1:W] ≥ divisor.
  - If either holds, go directly IDLE→DONE, with quotient={W{1}}, remainder=dividend[W-1:0] and err=1. out_valid is high one edge after accept.
  - err is cleared at the next accept.
- DIV_OVF_CHECK_EN undefined:
  - No check logic; err is tied 0.
  - All operations take W cycles.
  - quotient and remainder are unspecified for overflowing or zero-divisor inputs.

## Test plan
- Exact division, W=8: dividend=0x5A3C (23100), divisor=0xC8 (200) → quotient=0x73 (115), remainder=0x64 (100), err=0. out_valid is high after edge A+8.
- Product round-trip: all x,y ∈ 0..255 with y≠0, dividend=x·y → quotient=x, remainder=0. Back-to-back operations, with in_valid held high and out_ready held high, give one result every 10 cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. quotient, remainder and out_valid stay stable and in_ready stays 0. Toggling the inputs during this time has no effect.
- Boundary cases:
  - dividend=0x00FF, divisor=0x01 → quotient=0xFF, remainder=0.
  - dividend=0xFEFF, divisor=0xFF → quotient=0xFF, remainder=0xFE.
  - dividend=0, divisor=0x07 → quotient=0, remainder=0.
- Reset mid-operation: assert rst_n=0 at A+4, asynchronously between edges. Outputs go to reset values immediately. After release, a fresh operation (0x0400 / 0x10) gives quotient=0x40, remainder=0.
- With DIV_OVF_CHECK_EN:
  - divisor=0, dividend=0x1234 → err=1, quotient=0xFF, remainder=0x34, out_valid after A+1.
  - dividend=0x2000, divisor=0x10 → err=1.
  - The next legal operation clears err.

Source files
------------

// File: rtl/unsigned_seq_divider.sv
// rtl/unsigned_seq_divider.sv - restoring unsigned divider, 2W/W -> W quotient + W remainder, one bit per clock; optional DIV_OVF_CHECK_EN
module unsigned_seq_divider #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             err
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_div;
    logic [CW-1:0]  r_cnt;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [W-1:0]   r_quotient;
    logic [W-1:0]   r_remainder;

    // The partial remainder always stays below the divisor, so its top bit is
    // never set between steps and only the shifted-in trial value needs W+1 bits.
    logic [W:0]     w_trial;
    logic           w_ge;
    logic [W-1:0]   w_rem_next;
    logic [W-1:0]   w_q_next;
    logic           w_last;

    assign w_trial    = {r_rem, r_q[W-1]};
    assign w_ge       = (w_trial >= {1'b0, r_div});
    // A restored difference is smaller than the divisor, so the borrow out of bit W can be dropped.
    assign w_rem_next = w_ge ? (w_trial[W-1:0] - r_div) : w_trial[W-1:0];
    assign w_q_next   = {r_q[W-2:0], w_ge};
    assign w_last     = (r_cnt == CW'(W - 1));

`ifdef DIV_OVF_CHECK_EN
    logic w_ovf;
    logic r_err;

    // Zero divisor, or a high half that already reaches the divisor, cannot yield a W-bit quotient.
    assign w_ovf = (divisor == '0) || (dividend[2*W-1:W] >= divisor);

    // Error flag is decided at every accept, so a legal operation clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_err <= w_ovf;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Control FSM plus datapath: accept, W shift/subtract steps, then hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef DIV_OVF_CHECK_EN
                        if (w_ovf) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= dividend[W-1:0];
                        end else
`endif
                        begin
                            r_div      <= divisor;
                            r_rem      <= dividend[2*W-1:W];
                            r_q        <= dividend[W-1:0];
                            r_cnt      <= '0;
                            r_state    <= S_BUSY;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_unsigned_seq_divider.sv
// tb/tb_unsigned_seq_divider.sv - self-checking bench for unsigned_seq_divider (W=8)
`timescale 1ns/1ps
module tb_unsigned_seq_divider;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           err;

    int n_vec;
    int n_miss;
    int cyc;

    unsigned_seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One full transaction: present, wait for accept, scramble inputs, wait for result, check, drain.
    task automatic run_op(input string nm, input logic [15:0] dd, input logic [7:0] dv,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee, input int elat);
        bit got;
        int lat;
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        got = 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = 1;
                lat = i;
                break;
            end
        end
        if (!got) begin
            chk({nm, "_result_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_quotient"}, quotient, eq);
        chk({nm, "_remainder"}, remainder, er);
        chk({nm, "_err"}, err, ee);
        chk({nm, "_in_ready_done"}, in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, "_drain_out_valid"}, out_valid, 1'b0);
        chk({nm, "_drain_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] bb_dd[20];
        logic [7:0]  bb_dv[20];
        int          bb_acc[20];
        int          x, y, qv, rv;
        bit          got;

        n_vec     = 0;
        n_miss    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        tbl[0] = '{16'h5A3C, 8'hC8, 8'h73, 8'h64};
        tbl[1] = '{16'h00FF, 8'h01, 8'hFF, 8'h00};
        tbl[2] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE};
        tbl[3] = '{16'h0000, 8'h07, 8'h00, 8'h00};
        tbl[4] = '{16'h0400, 8'h10, 8'h40, 8'h00};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_quotient", quotient, 8'h00);
        chk("rst_remainder", remainder, 8'h00);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, 1'b0, W);
        end

        // random product round-trip: z = x*y must divide back to x with no remainder
        for (int i = 0; i < 150; i++) begin
            x = $urandom_range(0, 255);
            y = $urandom_range(1, 255);
            run_op($sformatf("prod%0d_%0dx%0d", i, x, y), 16'(x * y), 8'(y), 8'(x), 8'h00, 1'b0, W);
        end

        // random legal quotient/remainder pairs against plain division
        for (int i = 0; i < 100; i++) begin
            y  = $urandom_range(1, 255);
            qv = $urandom_range(0, 255);
            rv = $urandom_range(0, y - 1);
            x  = qv * y + rv;
            run_op($sformatf("rnd%0d", i), 16'(x), 8'(y), 8'(x / y), 8'(x % y), 1'b0, W);
        end

        // backpressure: result and handshakes frozen while inputs toggle
        dividend = 16'd23100;
        divisor  = 8'd200;
        in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_reached_done", out_valid & got, 1'b1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
            chk($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
            chk($sformatf("bp%0d_quotient", i), quotient, 8'h73);
            chk($sformatf("bp%0d_remainder", i), remainder, 8'h64);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_drain_in_ready", in_ready, 1'b1);

        // back-to-back with in_valid and out_ready held high: one result per W+2 cycles
        for (int k = 0; k < 20; k++) begin
            y = $urandom_range(1, 255);
            x = $urandom_range(0, 255);
            bb_dd[k] = 16'(x * y);
            bb_dv[k] = 8'(y);
        end
        out_ready = 1'b1;
        dividend  = bb_dd[0];
        divisor   = bb_dv[0];
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            got = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1;
                    break;
                end
            end
            @(posedge clk);
            bb_acc[k] = cyc;
            #1;
            if (k < 19) begin
                dividend = bb_dd[k+1];
                divisor  = bb_dv[k+1];
            end else begin
                in_valid = 1'b0;
            end
            got = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = 1;
                    break;
                end
            end
            chk($sformatf("bb%0d_got", k), got, 1'b1);
            chk($sformatf("bb%0d_quotient", k), quotient, 8'(bb_dd[k] / bb_dv[k]));
            chk($sformatf("bb%0d_remainder", k), remainder, 8'(bb_dd[k] % bb_dv[k]));
            if (k > 0) chk($sformatf("bb%0d_interval", k), bb_acc[k] - bb_acc[k-1], W + 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // asynchronous reset in the middle of an operation
        dividend = 16'h5A3C;
        divisor  = 8'hC8;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_quotient", quotient, 8'h00);
        chk("midrst_remainder", remainder, 8'h00);
        chk("midrst_err", err, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_rst", 16'h0400, 8'h10, 8'h40, 8'h00, 1'b0, W);

`ifdef DIV_OVF_CHECK_EN
        run_op("ovf_div0", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1);
        run_op("ovf_high", 16'h2000, 8'h10, 8'hFF, 8'h00, 1'b1, 1);
        run_op("ovf_clear", 16'h5A3C, 8'hC8, 8'h73, 8'h64, 1'b0, W);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
